// File: rtl/round_robin_arbiter_if.sv
// Request/grant bundle between requester kernels and the round-robin arbiter.
interface round_robin_arbiter_if #(
    parameter int N = 4
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]  req;
    logic [N-1:0]  grant;
    logic          grant_valid;
    logic [IW-1:0] grant_id;
    logic          preempt;
    logic          busy;

    // Requester side drives requests and observes the grant.
    modport master (
        output req,
        input  grant, grant_valid, grant_id, preempt, busy
    );

    // Arbiter side observes requests and drives the grant.
    modport slave (
        input  req,
        output grant, grant_valid, grant_id, preempt, busy
    );
endinterface

// File: rtl/round_robin_arbiter.sv
// Round-robin arbiter for one shared downstream resource.
// Registered one-hot grant, bounded hold time, back-to-back handover
// with no dead cycle, and a preempt pulse when a grant is cut by expiry.
//
// state   | meaning
// --------+--------------------------------------------------
// IDLE    | no grant outstanding, searching from ptr
// GRANTED | grant_id owns the resource, hold counter running
module round_robin_arbiter #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8
) (
    input logic [1:0]             clock_reset,
    round_robin_arbiter_if.slave  bus
);
    localparam int              IW       = (N > 1) ? $clog2(N) : 1;
    localparam logic [7:0]      HOLD_LIM = 8'(MAX_HOLD);
    localparam logic [IW:0]     N_W      = (IW+1)'(N);
    localparam logic [IW-1:0]   LAST     = IW'(N - 1);

    typedef enum logic {IDLE, GRANTED} state_t;

    logic clk;
    logic rst;
    assign clk = clock_reset[0];
    assign rst = clock_reset[1];

    state_t        state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] gid_q, gid_d;
    logic [7:0]    hold_q, hold_d;
    logic [N-1:0]  grant_q, grant_d;
    logic          pre_q, pre_d;

    logic          cur_req;
    logic          at_limit;
    logic          end_of_grant;
    logic [IW-1:0] next_ptr;
    logic [IW-1:0] start;
    logic [IW-1:0] cand;
    logic [N-1:0]  cand_onehot;
    logic          found;

    assign cur_req      = bus.req[gid_q];
    assign at_limit     = (hold_q == HOLD_LIM);
    assign end_of_grant = (state_q == GRANTED) && (!cur_req || at_limit);
    assign next_ptr     = (gid_q == LAST) ? '0 : gid_q + IW'(1);
    // On end-of-grant the search restarts just past the outgoing owner in the same cycle.
    assign start        = end_of_grant ? next_ptr : ptr_q;

    // Rotating priority search: first active request at or after start, wrapping mod N.
    always_comb begin
        logic [IW:0] sum;
        found       = 1'b0;
        cand        = '0;
        cand_onehot = '0;
        sum         = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, start} + (IW+1)'(k);
            if (sum >= N_W) sum = sum - N_W;
            if (!found && bus.req[sum[IW-1:0]]) begin
                found = 1'b1;
                cand  = sum[IW-1:0];
            end
        end
        cand_onehot[cand] = found;
    end

    // Next-state and next-grant decision.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gid_d   = gid_q;
        hold_d  = hold_q;
        grant_d = grant_q;
        pre_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = GRANTED;
                    gid_d   = cand;
                    hold_d  = 8'd1;
                    grant_d = cand_onehot;
                end
            end
            GRANTED: begin
                if (!end_of_grant) begin
                    hold_d = hold_q + 8'd1;
                end else begin
                    ptr_d = next_ptr;
                    // A release in the expiry cycle is a normal release, not a preemption.
                    pre_d = cur_req && at_limit;
                    if (found) begin
                        gid_d   = cand;
                        hold_d  = 8'd1;
                        grant_d = cand_onehot;
                    end else begin
                        state_d = IDLE;
                        gid_d   = '0;
                        hold_d  = 8'd0;
                        grant_d = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gid_q   <= '0;
            hold_q  <= 8'd0;
            grant_q <= '0;
            pre_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gid_q   <= gid_d;
            hold_q  <= hold_d;
            grant_q <= grant_d;
            pre_q   <= pre_d;
        end
    end

    assign bus.grant       = grant_q;
    assign bus.grant_valid = (state_q == GRANTED);
    assign bus.grant_id    = gid_q;
    assign bus.preempt     = pre_q;
    assign bus.busy        = |bus.req;
endmodule

// File: tb/tb_round_robin_arbiter.sv
// Directed bench for round_robin_arbiter with N=4, MAX_HOLD=3.
module tb_round_robin_arbiter;
    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    typedef struct packed {
        logic [3:0] grant;
        logic [1:0] id;
        logic       pre;
    } exp_t;

    exp_t sb[$];

    round_robin_arbiter_if #(.N(4)) bus ();

    round_robin_arbiter #(.N(4), .MAX_HOLD(3)) dut (
        .clock_reset ({rst, clk}),
        .bus         (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input logic [3:0] r, input logic rs, input logic [3:0] eg,
                        input logic [1:0] eid, input logic ep, input string tag);
        exp_t e;
        exp_t o;
        @(negedge clk);
        bus.req = r;
        rst     = rs;
        e.grant = eg;
        e.id    = eid;
        e.pre   = ep;
        sb.push_back(e);
        #1;
        checks++;
        assert (bus.busy === (|r)) else begin
            failures++;
            $error("FAIL %s busy got %b exp %b", tag, bus.busy, |r);
        end
        @(posedge clk);
        #1;
        o = sb.pop_front();
        checks++;
        assert (bus.grant === o.grant) else begin
            failures++;
            $error("FAIL %s grant got %b exp %b", tag, bus.grant, o.grant);
        end
        checks++;
        assert (bus.grant_valid === (|o.grant)) else begin
            failures++;
            $error("FAIL %s grant_valid got %b exp %b", tag, bus.grant_valid, |o.grant);
        end
        checks++;
        assert (bus.grant_id === o.id) else begin
            failures++;
            $error("FAIL %s grant_id got %0d exp %0d", tag, bus.grant_id, o.id);
        end
        checks++;
        assert (bus.preempt === o.pre) else begin
            failures++;
            $error("FAIL %s preempt got %b exp %b", tag, bus.preempt, o.pre);
        end
    endtask

    initial begin
        rst     = 1'b1;
        bus.req = 4'b0000;

        // reset with all requests pending
        step(4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, "rst0");
        step(4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, "rst1");

        // full contention, rotation with preempt at each handover
        step(4'b1111, 1'b0, 4'b0001, 2'd0, 1'b0, "full_g0a");
        step(4'b1111, 1'b0, 4'b0001, 2'd0, 1'b0, "full_g0b");
        step(4'b1111, 1'b0, 4'b0001, 2'd0, 1'b0, "full_g0c");
        step(4'b1111, 1'b0, 4'b0010, 2'd1, 1'b1, "full_g1a");
        step(4'b1111, 1'b0, 4'b0010, 2'd1, 1'b0, "full_g1b");
        step(4'b1111, 1'b0, 4'b0010, 2'd1, 1'b0, "full_g1c");
        step(4'b1111, 1'b0, 4'b0100, 2'd2, 1'b1, "full_g2a");
        step(4'b1111, 1'b0, 4'b0100, 2'd2, 1'b0, "full_g2b");
        step(4'b1111, 1'b0, 4'b0100, 2'd2, 1'b0, "full_g2c");
        step(4'b1111, 1'b0, 4'b1000, 2'd3, 1'b1, "full_g3a");
        step(4'b1111, 1'b0, 4'b1000, 2'd3, 1'b0, "full_g3b");
        step(4'b1111, 1'b0, 4'b1000, 2'd3, 1'b0, "full_g3c");
        step(4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1, "full_wrap");
        step(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, "full_idle");

        // single requester: expiry then self re-grant with preempt
        step(4'b0100, 1'b0, 4'b0100, 2'd2, 1'b0, "single_a");
        step(4'b0100, 1'b0, 4'b0100, 2'd2, 1'b0, "single_b");
        step(4'b0100, 1'b0, 4'b0100, 2'd2, 1'b0, "single_c");
        step(4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, "single_regrant");
        step(4'b0100, 1'b0, 4'b0100, 2'd2, 1'b0, "single_hold");
        step(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, "single_idle");

        // early release hands over with no gap
        step(4'b0011, 1'b0, 4'b0001, 2'd0, 1'b0, "early_g0");
        step(4'b0010, 1'b0, 4'b0010, 2'd1, 1'b0, "early_g1");
        step(4'b0010, 1'b0, 4'b0010, 2'd1, 1'b0, "early_g1b");

        // pointer wrap from index 3 back to 0
        step(4'b1000, 1'b0, 4'b1000, 2'd3, 1'b0, "wrap_g3");
        step(4'b1001, 1'b0, 4'b1000, 2'd3, 1'b0, "wrap_g3b");
        step(4'b1001, 1'b0, 4'b1000, 2'd3, 1'b0, "wrap_g3c");
        step(4'b1001, 1'b0, 4'b0001, 2'd0, 1'b1, "wrap_g0");
        step(4'b1000, 1'b0, 4'b1000, 2'd3, 1'b0, "wrap_back3");

        // release coinciding with expiry counts as release
        step(4'b1000, 1'b0, 4'b1000, 2'd3, 1'b0, "relexp_h2");
        step(4'b1000, 1'b0, 4'b1000, 2'd3, 1'b0, "relexp_h3");
        step(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, "relexp_idle");

        // reset mid-grant with a non-zero pointer, pointer must return to 0
        step(4'b0010, 1'b0, 4'b0010, 2'd1, 1'b0, "rmid_a");
        step(4'b0010, 1'b0, 4'b0010, 2'd1, 1'b0, "rmid_b");
        step(4'b0010, 1'b0, 4'b0010, 2'd1, 1'b0, "rmid_c");
        step(4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, "rmid_regrant");
        step(4'b0010, 1'b0, 4'b0010, 2'd1, 1'b0, "rmid_h2");
        step(4'b0010, 1'b1, 4'b0000, 2'd0, 1'b0, "rmid_reset");
        step(4'b0110, 1'b0, 4'b0010, 2'd1, 1'b0, "rmid_after");
        step(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, "final_idle");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
